// File: rtl/scmp_useq.sv
// SC/MP microprogram sequencer: microcode PC with relative branches, opcode
// dispatch, trap vector, a hardware return stack and a bus-wait stall.
module scmp_useq #(
  parameter int unsigned    PC_W     = 8,
  parameter int unsigned    OFF_W    = 8,
  parameter int unsigned    NCOND    = 5,
  parameter int unsigned    STACK_D  = 2,
  parameter logic [PC_W-1:0] TRAP_VEC = 'hF0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             stall_i,
  input  logic [NCOND-1:0]                 cond_in_i,
  input  logic [NCOND-1:0]                 uc_cond_mask_i,
  input  logic [NCOND-1:0]                 uc_cond_xor_i,
  input  logic                             uc_decode_i,
  input  logic                             uc_call_i,
  input  logic                             uc_ret_i,
  input  logic [OFF_W-1:0]                 uc_next_i,
  input  logic [PC_W-1:0]                  op_pc_i,
  input  logic                             trap_req_i,
  input  logic                             clr_err_i,
  output logic [PC_W-1:0]                  mc_pc_o,
  output logic                             cond_o,
  output logic [$clog2(STACK_D+1)-1:0]     sp_level_o,
  output logic                             trap_taken_o,
  output logic                             stack_ovf_o,
  output logic                             stack_unf_o
);

  localparam int unsigned SpW = $clog2(STACK_D + 1);

  logic [PC_W-1:0] mc_pc_q, mc_pc_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            trap_q, trap_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PC_W-1:0] stack_q [STACK_D];
  logic            push_en;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] stack_top;
  logic            stack_empty;
  logic            stack_full;

  assign cond_o = |((cond_in_i ^ uc_cond_xor_i) & uc_cond_mask_i);

  // Offset is signed; the size cast sign-extends it to the PC width.
  assign pc_inc      = mc_pc_q + PC_W'(1);
  assign pc_rel      = mc_pc_q + PC_W'($signed(uc_next_i));
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SpW'(STACK_D));

  // Top-of-stack read: entry sp_q-1 (zero when the stack is empty).
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_D; i++) begin
      if (sp_q == SpW'(i + 1)) stack_top = stack_q[i];
    end
  end

  // Next-state selection by strict priority: decode, skip, ret, call, fetch, branch.
  always_comb begin
    mc_pc_d = mc_pc_q;
    sp_d    = sp_q;
    trap_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!stall_i) begin
      // Clear first so that a same-cycle error set below takes precedence.
      if (clr_err_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (uc_decode_i) begin
        if (trap_req_i) begin
          mc_pc_d = TRAP_VEC;
          trap_d  = 1'b1;
        end else begin
          mc_pc_d = op_pc_i;
        end
      end else if (cond_o) begin
        mc_pc_d = pc_inc;
      end else if (uc_ret_i) begin
        if (!stack_empty) begin
          mc_pc_d = stack_top;
          sp_d    = sp_q - SpW'(1);
        end else begin
          mc_pc_d = '0;
          unf_d   = 1'b1;
        end
      end else if (uc_call_i) begin
        mc_pc_d = pc_rel;
        if (!stack_full) begin
          push_en = 1'b1;
          sp_d    = sp_q + SpW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (uc_next_i == '0) begin
        mc_pc_d = '0;
      end else begin
        mc_pc_d = pc_rel;
      end
    end
  end

  // Sequencer control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mc_pc_q <= '0;
      sp_q    <= '0;
      trap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mc_pc_q <= mc_pc_d;
      sp_q    <= sp_d;
      trap_q  <= trap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return stack storage: a push writes the return address at slot sp_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STACK_D; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      for (int i = 0; i < STACK_D; i++) begin
        if (sp_q == SpW'(i)) stack_q[i] <= pc_inc;
      end
    end
  end

  assign mc_pc_o      = mc_pc_q;
  assign sp_level_o   = sp_q;
  assign trap_taken_o = trap_q;
  assign stack_ovf_o  = ovf_q;
  assign stack_unf_o  = unf_q;

endmodule

// File: tb/tb_scmp_useq.sv
// Directed bench for scmp_useq with an expectation queue checked after each edge.
module tb_scmp_useq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [4:0] cond_in, mask, xorv;
  logic       decode, call, ret, trap_req, clr_err;
  logic [7:0] nxt, op_pc;
  logic [7:0] mc_pc;
  logic       cond;
  logic [1:0] sp_level;
  logic       trap_taken, ovf, unf;

  always #5 clk = ~clk;

  scmp_useq dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .cond_in_i      (cond_in),
    .uc_cond_mask_i (mask),
    .uc_cond_xor_i  (xorv),
    .uc_decode_i    (decode),
    .uc_call_i      (call),
    .uc_ret_i       (ret),
    .uc_next_i      (nxt),
    .op_pc_i        (op_pc),
    .trap_req_i     (trap_req),
    .clr_err_i      (clr_err),
    .mc_pc_o        (mc_pc),
    .cond_o         (cond),
    .sp_level_o     (sp_level),
    .trap_taken_o   (trap_taken),
    .stack_ovf_o    (ovf),
    .stack_unf_o    (unf)
  );

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [1:0] sp;
    logic       trap;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   mc_pc,            e.pc);
      chk({e.tag, ".sp"},   8'(sp_level),     8'(e.sp));
      chk({e.tag, ".trap"}, 8'(trap_taken),   8'(e.trap));
      chk({e.tag, ".ovf"},  8'(ovf),          8'(e.ovf));
      chk({e.tag, ".unf"},  8'(unf),          8'(e.unf));
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] pc, input logic [1:0] sp,
                          input logic tr, input logic ov, input logic un);
    exp_t e;
    e.tag = tag; e.pc = pc; e.sp = sp; e.trap = tr; e.ovf = ov; e.unf = un;
    sb.push_back(e);
  endtask

  // One clocked step: queue the expected result, take the edge, compare.
  task automatic step(input string tag, input logic [7:0] pc, input logic [1:0] sp,
                      input logic tr, input logic ov, input logic un);
    push_exp(tag, pc, sp, tr, ov, un);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Compare without a clock edge (used around asynchronous reset).
  task automatic now(input string tag, input logic [7:0] pc, input logic [1:0] sp,
                     input logic tr, input logic ov, input logic un);
    push_exp(tag, pc, sp, tr, ov, un);
    check_pop();
  endtask

  task automatic idle();
    stall = 1'b0; cond_in = '0; mask = '0; xorv = '0;
    decode = 1'b0; call = 1'b0; ret = 1'b0; trap_req = 1'b0; clr_err = 1'b0;
    nxt = 8'h00; op_pc = 8'h00;
  endtask

  task automatic goto_w(input logic [7:0] a);
    idle(); decode = 1'b1; op_pc = a;
  endtask

  task automatic next_w(input logic [7:0] n);
    idle(); nxt = n;
  endtask

  task automatic call_w(input logic [7:0] n);
    idle(); call = 1'b1; nxt = n;
  endtask

  task automatic ret_w();
    idle(); ret = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    now("reset", 8'h00, 2'd0, 0, 0, 0);
    rst_n = 1'b1;

    // Sequential fetch and wrap
    next_w(8'h01);
    step("inc1", 8'h01, 2'd0, 0, 0, 0);
    step("inc2", 8'h02, 2'd0, 0, 0, 0);
    step("inc3", 8'h03, 2'd0, 0, 0, 0);
    goto_w(8'hFF);  step("to_ff", 8'hFF, 2'd0, 0, 0, 0);
    next_w(8'h01);  step("wrap",  8'h00, 2'd0, 0, 0, 0);

    // Dispatch and trap
    goto_w(8'h10);  step("to_10", 8'h10, 2'd0, 0, 0, 0);
    goto_w(8'h42);  step("disp",  8'h42, 2'd0, 0, 0, 0);
    goto_w(8'h10);  step("to_10b", 8'h10, 2'd0, 0, 0, 0);
    goto_w(8'h42); trap_req = 1'b1;
    step("trap", 8'hF0, 2'd0, 1, 0, 0);
    next_w(8'h01);  step("trap_end", 8'hF1, 2'd0, 0, 0, 0);

    // Nested subroutines
    goto_w(8'h20);  step("to_20", 8'h20, 2'd0, 0, 0, 0);
    call_w(8'h08);  step("call1", 8'h28, 2'd1, 0, 0, 0);
    call_w(8'h10);  step("call2", 8'h38, 2'd2, 0, 0, 0);
    ret_w();        step("ret2",  8'h29, 2'd1, 0, 0, 0);
    ret_w();        step("ret1",  8'h21, 2'd0, 0, 0, 0);

    // Overflow keeps the top entry; underflow goes to 0
    call_w(8'h08);  step("fill1", 8'h29, 2'd1, 0, 0, 0);
    call_w(8'h08);  step("fill2", 8'h31, 2'd2, 0, 0, 0);
    call_w(8'h08);  step("ovf",   8'h39, 2'd2, 0, 1, 0);
    ret_w();        step("pop_a", 8'h2A, 2'd1, 0, 1, 0);
    ret_w();        step("pop_b", 8'h22, 2'd0, 0, 1, 0);
    ret_w();        step("unf",   8'h00, 2'd0, 0, 1, 1);
    next_w(8'h01); clr_err = 1'b1;
    step("clr", 8'h01, 2'd0, 0, 0, 0);
    call_w(8'h01);  step("fill3", 8'h02, 2'd1, 0, 0, 0);
    call_w(8'h01);  step("fill4", 8'h03, 2'd2, 0, 0, 0);
    call_w(8'h01); clr_err = 1'b1;
    step("ovf_vs_clr", 8'h04, 2'd2, 0, 1, 0);
    next_w(8'h01); stall = 1'b1; clr_err = 1'b1;
    step("clr_stalled", 8'h04, 2'd2, 0, 1, 0);
    next_w(8'h01); clr_err = 1'b1;
    step("clr2", 8'h05, 2'd2, 0, 0, 0);

    // Conditional skip of ret, then a real pop; ret beats call
    goto_w(8'h30);  step("to_30", 8'h30, 2'd2, 0, 0, 0);
    ret_w(); mask = 5'b00001; cond_in = 5'b00001;
    #1 chk("cond_hi", 8'(cond), 8'h01);
    step("skip_ret", 8'h31, 2'd2, 0, 0, 0);
    ret_w(); mask = 5'b00001; cond_in = 5'b00000;
    #1 chk("cond_lo", 8'(cond), 8'h00);
    step("do_ret", 8'h03, 2'd1, 0, 0, 0);
    ret_w(); call = 1'b1; nxt = 8'h05;
    step("ret_wins", 8'h02, 2'd0, 0, 0, 0);
    idle(); mask = 5'b00100; xorv = 5'b00100;
    #1 chk("cond_xor", 8'(cond), 8'h01);
    step("skip_xor", 8'h03, 2'd0, 0, 0, 0);
    idle(); cond_in = 5'b11111;
    step("fetch0", 8'h00, 2'd0, 0, 0, 0);

    // Stall, negative offset, reset mid-stall
    goto_w(8'h50);  step("to_50", 8'h50, 2'd0, 0, 0, 0);
    next_w(8'hF0); stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall", 8'h50, 2'd0, 0, 0, 0);
    goto_w(8'h00); trap_req = 1'b1; stall = 1'b1; mask = 5'b00001; cond_in = 5'b00001;
    #1 chk("cond_stall", 8'(cond), 8'h01);
    step("trap_stall", 8'h50, 2'd0, 0, 0, 0);
    next_w(8'hF0);  step("neg_off", 8'h40, 2'd0, 0, 0, 0);
    call_w(8'h10);  step("call_s", 8'h50, 2'd1, 0, 0, 0);
    next_w(8'h01); stall = 1'b1;
    step("stall_sub", 8'h50, 2'd1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 now("rst_mid", 8'h00, 2'd0, 0, 0, 0);
    rst_n = 1'b1;
    next_w(8'h01);  step("post_rst", 8'h01, 2'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
